// File: rtl/data_ctrl.sv
// data_ctrl: byte-serial load/store engine between the load
// buffer / reorder buffer and the byte-wide RAM port.
module data_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        lbuffer_datactrl_en_in,
  input  logic [31:0] lbuffer_datactrl_addr_in,
  input  logic [2:0]  lbuffer_datactrl_width_in,
  input  logic        lbuffer_datactrl_signed_in,
  output logic        datactrl_lbuffer_en_out,
  output logic [31:0] datactrl_lbuffer_data_out,
  input  logic        rob_datactrl_en_in,
  input  logic [31:0] rob_datactrl_addr_in,
  input  logic [2:0]  rob_datactrl_width_in,
  input  logic [31:0] rob_datactrl_data_in,
  output logic        datactrl_rob_en_out,
  input  logic        rob_datactrl_rst_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } state_t;

  function automatic logic [2:0] width_of(
    input logic [2:0] enc
  );
    logic [2:0] w;
    unique case (1'b1)
      (enc == 3'b010): w = 3'd2;
      (enc == 3'b100): w = 3'd4;
      default:         w = 3'd1;
    endcase
    return w;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic [31:0] buf_q;
  logic [31:0] ldata_q;
  logic [2:0]  w_q;
  logic [2:0]  k_q;
  logic [1:0]  pk_q;
  logic        pend_q;
  logic        sgn_q;
  logic        ld_done_q;
  logic        st_done_q;

  logic        flush;
  logic        acc_st;
  logic        acc_ld;
  logic        issue;
  logic        last_cap;
  logic        st_last;
  logic [1:0]  sel;
  logic [31:0] asm_v;
  logic [31:0] ext_v;

  // A requester still high in its own done cycle is not re-taken.
  assign flush    = rob_datactrl_rst_in;
  assign acc_st   = rob_datactrl_en_in && !st_done_q;
  assign acc_ld   = lbuffer_datactrl_en_in && !ld_done_q
                    && !flush;
  assign issue    = k_q < w_q;
  assign last_cap = pend_q && ({1'b0, pk_q} == w_q - 3'd1);
  assign st_last  = k_q == w_q - 3'd1;

  assign datactrl_lbuffer_en_out   = ld_done_q;
  assign datactrl_lbuffer_data_out = ldata_q;
  assign datactrl_rob_en_out       = st_done_q;

  // Merge the arriving byte and extend the final load value.
  always_comb begin
    asm_v = buf_q;
    asm_v[{pk_q, 3'b000} +: 8] = mem_din;
    unique case (1'b1)
      (w_q == 3'd1):
        ext_v = {{24{sgn_q & asm_v[7]}}, asm_v[7:0]};
      (w_q == 3'd2):
        ext_v = {{16{sgn_q & asm_v[15]}}, asm_v[15:0]};
      default:
        ext_v = asm_v;
    endcase
  end

  // State register; a stall freezes it.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  // Next-state selection; stores win over loads.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (acc_st) begin
          state_d = STORE;
        end else if (acc_ld) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (flush || last_cap) begin
          state_d = IDLE;
        end
      end
      STORE: begin
        if (st_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, byte counters, assembly and done pulses.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      addr_q    <= '0;
      sdata_q   <= '0;
      buf_q     <= '0;
      ldata_q   <= '0;
      w_q       <= 3'd1;
      k_q       <= '0;
      pk_q      <= '0;
      pend_q    <= 1'b0;
      sgn_q     <= 1'b0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
    end else if (rdy_in) begin
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          k_q    <= '0;
          pk_q   <= '0;
          pend_q <= 1'b0;
          if (acc_st) begin
            addr_q  <= rob_datactrl_addr_in;
            sdata_q <= rob_datactrl_data_in;
            w_q     <= width_of(rob_datactrl_width_in);
          end else if (acc_ld) begin
            addr_q <= lbuffer_datactrl_addr_in;
            w_q    <= width_of(lbuffer_datactrl_width_in);
            sgn_q  <= lbuffer_datactrl_signed_in;
            buf_q  <= '0;
          end
        end
        LOAD: begin
          if (flush) begin
            k_q    <= '0;
            pend_q <= 1'b0;
          end else begin
            if (pend_q) begin
              buf_q[{pk_q, 3'b000} +: 8] <= mem_din;
            end
            if (last_cap) begin
              ldata_q   <= ext_v;
              ld_done_q <= 1'b1;
              k_q       <= '0;
              pend_q    <= 1'b0;
            end else if (issue) begin
              pend_q <= 1'b1;
              pk_q   <= k_q[1:0];
              k_q    <= k_q + 3'd1;
            end
          end
        end
        STORE: begin
          if (st_last) begin
            st_done_q <= 1'b1;
            k_q       <= '0;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        default: k_q <= '0;
      endcase
    end
  end

  // RAM port; while stalled, keep the in-flight byte's address up.
  always_comb begin
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = '0;
    sel      = (!rdy_in || !issue) ? pk_q : k_q[1:0];
    unique case (state_q)
      LOAD: begin
        mem_a = addr_q + {30'd0, sel};
      end
      STORE: begin
        mem_a  = addr_q + {29'd0, k_q};
        mem_wr = rdy_in;
        if (rdy_in) begin
          mem_dout = sdata_q[{k_q[1:0], 3'b000} +: 8];
        end
      end
      default: mem_a = '0;
    endcase
  end

endmodule

// File: tb/tb_data_ctrl.sv
// tb_data_ctrl: directed transactions against a timeline model
// of data_ctrl plus a byte RAM with one-cycle read latency.
module tb_data_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        lb_en;
  logic [31:0] lb_addr;
  logic [2:0]  lb_width;
  logic        lb_sgn;
  logic        lb_en_o;
  logic [31:0] data_o;
  logic        rob_en;
  logic [31:0] rob_addr;
  logic [2:0]  rob_width;
  logic [31:0] rob_data;
  logic        rob_en_o;
  logic        flush;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int total = 0;
  int bad = 0;
  int cnt = 0;
  logic [31:0] hold = '0;

  logic [7:0]  ram [0:4095];
  logic [7:0]  mdl [0:4095];
  logic [31:0] exp_rda [int];
  logic [39:0] exp_wra [int];
  logic [31:0] exp_ldd [int];
  bit          exp_std [int];

  data_ctrl dut (
    .clk_in                     (clk),
    .rst_in                     (rst),
    .rdy_in                     (rdy),
    .lbuffer_datactrl_en_in     (lb_en),
    .lbuffer_datactrl_addr_in   (lb_addr),
    .lbuffer_datactrl_width_in  (lb_width),
    .lbuffer_datactrl_signed_in (lb_sgn),
    .datactrl_lbuffer_en_out    (lb_en_o),
    .datactrl_lbuffer_data_out  (data_o),
    .rob_datactrl_en_in         (rob_en),
    .rob_datactrl_addr_in       (rob_addr),
    .rob_datactrl_width_in      (rob_width),
    .rob_datactrl_data_in       (rob_data),
    .datactrl_rob_en_out        (rob_en_o),
    .rob_datactrl_rst_in        (flush),
    .mem_din                    (mem_din),
    .mem_dout                   (mem_dout),
    .mem_a                      (mem_a),
    .mem_wr                     (mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 1;

  always @(posedge clk) begin
    mem_din <= ram[mem_a[11:0]];
    if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
  end

  task automatic chk(input string nm,
                     input logic [39:0] act,
                     input logic [39:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cnt, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_ldd.exists(cnt)) hold = exp_ldd[cnt];
    chk("lb_en", 40'(lb_en_o), 40'(exp_ldd.exists(cnt)));
    chk("ld_data", 40'(data_o), 40'(hold));
    chk("rob_en", 40'(rob_en_o), 40'(exp_std.exists(cnt)));
    chk("mem_wr", 40'(mem_wr), 40'(exp_wra.exists(cnt)));
    if (exp_wra.exists(cnt)) begin
      chk("wr_addr", 40'(mem_a), 40'(exp_wra[cnt][39:8]));
      chk("wr_data", 40'(mem_dout), 40'(exp_wra[cnt][7:0]));
    end else begin
      chk("dout_idle", 40'(mem_dout), 40'd0);
    end
    if (exp_rda.exists(cnt))
      chk("rd_addr", 40'(mem_a), 40'(exp_rda[cnt]));
  end

  function automatic int wof(input logic [2:0] e);
    if (e == 3'b010) return 2;
    if (e == 3'b100) return 4;
    return 1;
  endfunction

  function automatic logic [31:0] ldval(
    input logic [31:0] a, input int w, input bit s);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < w; k++)
      v[8*k +: 8] = mdl[12'(a + 32'(k))];
    if (s && w == 1 && v[7]) v = v | 32'hFFFF_FF00;
    if (s && w == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic put(input logic [31:0] a,
                     input logic [7:0] b);
    ram[a[11:0]] = b;
    mdl[a[11:0]] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // st/ld select the requests; fl = flush at issue index,
  // so/sl = stall start index and length for the load.
  task automatic txn(
    input bit st, input logic [31:0] sa,
    input logic [2:0] sw, input logic [31:0] sd,
    input bit ld, input logic [31:0] la,
    input logic [2:0] lw, input bit ls,
    input int fl, input int so, input int sl,
    input logic [31:0] lit);
    int c, lc, ws, wl, sh, fin;
    int stdone, lddone, flc;
    logic [31:0] v;
    c = cnt;
    stdone = -1;
    lddone = -1;
    flc = -1;
    sh = (so >= 0) ? sl : 0;
    ws = wof(sw);
    wl = wof(lw);
    if (st) begin
      for (int k = 0; k < ws; k++) begin
        exp_wra[c+1+k] = {sa + 32'(k), sd[8*k +: 8]};
        mdl[12'(sa + 32'(k))] = sd[8*k +: 8];
      end
      stdone = c + ws + 1;
      exp_std[stdone] = 1'b1;
    end
    lc = st ? stdone : c;
    if (ld) begin
      v = ldval(la, wl, ls);
      for (int k = 0; k < wl; k++) begin
        if (fl < 0 || k <= fl)
          exp_rda[lc+1+k+((so >= 0 && k >= so) ? sl : 0)]
            = la + 32'(k);
      end
      if (fl >= 0) begin
        flc = lc + 1 + fl;
      end else begin
        lddone = lc + wl + 2 + sh;
        exp_ldd[lddone] = v;
      end
    end else if (fl >= 0) begin
      flc = c + 1 + fl;
    end
    fin = stdone;
    if (lddone > fin) fin = lddone;
    if (flc > fin) fin = flc;
    rob_addr = sa;
    rob_width = sw;
    rob_data = sd;
    lb_addr = la;
    lb_width = lw;
    lb_sgn = ls;
    while (cnt <= fin + 1) begin
      rob_en = st && cnt <= stdone;
      lb_en = ld && ((fl >= 0) ? cnt < flc : cnt <= lddone);
      flush = (cnt == flc);
      rdy = !(so >= 0 && cnt >= lc + 1 + so
              && cnt <= lc + so + sl);
      if (cnt == lddone) begin
        chk("lit_data", 40'(data_o), 40'(lit));
        chk("lit_en", 40'(lb_en_o), 40'd1);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 8'h00;
      mdl[i] = 8'h00;
    end
    put(32'h0000_1003, 8'h80);
    put(32'h20, 8'h78);
    put(32'h21, 8'h56);
    put(32'h22, 8'h34);
    put(32'h23, 8'h12);
    put(32'h30, 8'hFF);
    put(32'h31, 8'h7F);
    put(32'h32, 8'h34);
    put(32'h33, 8'h85);
    put(32'hFFFF_FFFE, 8'h11);
    put(32'hFFFF_FFFF, 8'h22);
    put(32'h0, 8'h33);
    put(32'h1, 8'h44);

    rst = 1'b0;
    rdy = 1'b1;
    flush = 1'b0;
    lb_en = 1'b1;
    lb_addr = 32'h20;
    lb_width = 3'b100;
    lb_sgn = 1'b0;
    rob_en = 1'b1;
    rob_addr = 32'h40;
    rob_width = 3'b100;
    rob_data = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_a", 40'(mem_a), 40'd0);
      chk("rst_wr", 40'(mem_wr), 40'd0);
      chk("rst_lb", 40'(lb_en_o), 40'd0);
      chk("rst_rob", 40'(rob_en_o), 40'd0);
      chk("rst_data", 40'(data_o), 40'd0);
    end
    rst = 1'b1;
    lb_en = 1'b0;
    rob_en = 1'b0;
    tick();

    txn(0, 0, 0, 0, 1, 32'h1003, 3'b001, 1,
        -1, -1, 0, 32'hFFFF_FF80);
    txn(0, 0, 0, 0, 1, 32'h1003, 3'b001, 0,
        -1, -1, 0, 32'h0000_0080);
    txn(0, 0, 0, 0, 1, 32'h20, 3'b100, 0,
        -1, -1, 0, 32'h1234_5678);
    txn(0, 0, 0, 0, 1, 32'h30, 3'b010, 1,
        -1, -1, 0, 32'h0000_7FFF);
    txn(0, 0, 0, 0, 1, 32'h32, 3'b010, 1,
        -1, -1, 0, 32'hFFFF_8534);
    txn(1, 32'h40, 3'b100, 32'hDEAD_BEEF,
        1, 32'h40, 3'b100, 0,
        -1, -1, 0, 32'hDEAD_BEEF);
    txn(0, 0, 0, 0, 1, 32'h20, 3'b100, 0,
        1, -1, 0, 32'h0);
    txn(0, 0, 0, 0, 1, 32'h1003, 3'b001, 0,
        -1, -1, 0, 32'h0000_0080);
    txn(1, 32'h50, 3'b100, 32'h1122_3344,
        0, 0, 0, 0, 1, -1, 0, 32'h0);
    txn(0, 0, 0, 0, 1, 32'h50, 3'b100, 0,
        -1, -1, 0, 32'h1122_3344);
    txn(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 3'b100, 0,
        -1, 1, 3, 32'h4433_2211);
    txn(1, 32'h60, 3'b111, 32'h5566_77AB,
        0, 0, 0, 0, -1, -1, 0, 32'h0);
    txn(0, 0, 0, 0, 1, 32'h60, 3'b100, 0,
        -1, -1, 0, 32'h0000_00AB);
    txn(0, 0, 0, 0, 1, 32'h1003, 3'b000, 1,
        -1, -1, 0, 32'hFFFF_FF80);

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
